flit_packetizer: RTL and testbench
==================================

FLIT_PACKETIZER -- requirements
Module: flit_packetizer

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-002 SHALL have port arst, input, 1: reset, asynchronous, active-high.
REQ-003 SHALL have port pkt_valid_i, input, 1: packet request valid.
REQ-004 SHALL have port pkt_ready_o, output, 1: packet request accepted when both valid and ready are high.
REQ-005 SHALL have port pkt_dest_x_i, input, 4: destination X, route field [29:26].
REQ-006 SHALL have port pkt_dest_y_i, input, 4: destination Y, route field [25:22].
REQ-007 SHALL have port pkt_len_i, input, 4: payload flit count minus one (1..16 payload flits).
REQ-008 SHALL have port pkt_vc_i, input, 2: virtual channel for the packet.
REQ-009 SHALL have port word_i, input, 32: payload word.
REQ-010 SHALL have port word_valid_i, input, 1: payload word valid.
REQ-011 SHALL have port word_ready_o, output, 1: payload word accepted when both valid and ready are high.
REQ-012 SHALL have port fdata_o, output, 34: flit to vc_buffer; [33:32] type, [31:0] body.
REQ-013 SHALL have port valid_o, output, 1: flit valid.
REQ-014 SHALL have port ready_i, input, 1: downstream ready.
REQ-015 SHALL have port vc_id_o, output, 2: VC of the current flit.
REQ-016 SHALL have port err_o, output, 1: one-cycle pulse when a request is dropped.

Function
REQ-017 SHALL encode flit type as: 2'b00 head, 2'b01 body, 2'b11 tail; it SHALL never emit 2'b10.
REQ-018 SHALL format the head flit as: {2'b00, 2'b00, dest_x[3:0], dest_y[3:0], len[3:0], 18'b0}.
REQ-019 SHALL format each body or tail flit as: {type, word_i}.
REQ-020 SHALL drive all outputs except pkt_ready_o and word_ready_o from registers; fdata_o, valid_o and vc_id_o SHALL form one output register.
REQ-021 SHALL treat the output register as free in a cycle when !valid_o or ready_i is high.
REQ-022 SHALL implement an FSM with two states.
- IDLE: pkt_ready_o = free; word_ready_o = 0.
- PAYLOAD: word_ready_o = free; pkt_ready_o = 0.
REQ-023 SHALL, on a packet handshake in IDLE with a nonzero route field: load the head flit, set valid_o = 1, latch pkt_vc_i into vc_id_o, load the down-counter with pkt_len_i, and go to PAYLOAD.
- Latency: head flit is valid on the cycle after the handshake.
REQ-024 SHALL, on a packet handshake in IDLE with {dest_x, dest_y} == 0: consume the request, pulse err_o for one cycle, emit no flit, and stay in IDLE.
REQ-025 SHALL, on a word handshake in PAYLOAD:
- load a body flit if the counter is nonzero and decrement the counter;
- load a tail flit if the counter is zero and return to IDLE.
REQ-026 SHALL clear valid_o when ready_i is high and no new flit loads in that cycle.
REQ-027 SHALL hold fdata_o, valid_o and vc_id_o stable while valid_o && !ready_i.
REQ-028 SHALL sustain one flit per cycle with ready_i held high, including tail-to-next-head back-to-back.
REQ-029 SHALL keep vc_id_o constant from head to tail and hold its value while in IDLE.
REQ-030 SHALL ignore word_valid_i in IDLE and pkt_valid_i in PAYLOAD.

Reset
REQ-031 SHALL, while arst is high, immediately force: state IDLE, valid_o 0, fdata_o 0, vc_id_o 0, err_o 0, counter 0.
REQ-032 SHALL, on reset mid-packet, abandon the packet with no tail sent; the downstream route lock is cleared only by the downstream reset.

Configuration
REQ-033 SHALL, with macro FLIT_PACKETIZER_PKT_CNT_EN defined, add output pkt_cnt_o[15:0].
- Increments on each tail-flit output handshake (valid_o && ready_i && type 2'b11).
- Wraps from 0xFFFF to 0; reset value 0.
REQ-034 SHALL, without FLIT_PACKETIZER_PKT_CNT_EN, have no pkt_cnt_o port and no counter logic.

Verification
REQ-035 SHALL pass: reset, ready_i = 1, packet dest (2,3) len 0 vc 1, word 0xDEADBEEF -> head 0x008C00000, then tail {11, 0xDEADBEEF} on consecutive cycles; vc_id_o = 1 throughout.
REQ-036 SHALL pass: len 15 with words 0..15 -> 1 head, 15 body, 1 tail (word 15), with no bubbles when inputs are always valid.
REQ-037 SHALL pass: ready_i = 0 for 5 cycles during body flit 3 -> fdata_o and valid_o held, word_ready_o = 0, and no word lost or duplicated.
REQ-038 SHALL pass: request with dest (0,0) -> err_o high exactly one cycle, valid_o stays 0, next legal request is served normally.
REQ-039 SHALL pass: arst asserted mid-packet after body 2 -> valid_o = 0 asynchronously, state IDLE, and a new packet after release starts with a head flit.
REQ-040 SHALL pass, with FLIT_PACKETIZER_PKT_CNT_EN: 3 packets sent -> pkt_cnt_o = 3; preloaded at 0xFFFF, one more packet -> pkt_cnt_o = 0.

Source files
------------

// File: rtl/flit_packetizer.sv
// flit_packetizer
//
// Converts a packet request plus a stream of 32-bit payload words into NoC
// flits: one head flit carrying the route, then (len) body flits and one tail
// flit carrying the payload. fdata_o/valid_o/vc_id_o form a single output
// register with valid/ready flow control towards the VC buffer.
//
// Ports
//   clk, arst                 clock, asynchronous active-high reset
//   pkt_valid_i/pkt_ready_o   packet request handshake
//   pkt_dest_x_i/_y_i         destination coordinates (route field)
//   pkt_len_i                 payload flit count minus one
//   pkt_vc_i                  virtual channel for the whole packet
//   word_i/word_valid_i/      payload word handshake
//   word_ready_o
//   fdata_o                   flit: [33:32] type (00 head, 01 body, 11 tail)
//   valid_o/ready_i           flit handshake to the downstream buffer
//   vc_id_o                   VC of the flit currently presented
//   err_o                     one-cycle pulse when a request with route 0 is dropped
//   pkt_cnt_o                 tail-flit handshake counter (only with
//                             FLIT_PACKETIZER_PKT_CNT_EN defined)
//
// Configuration macro: FLIT_PACKETIZER_PKT_CNT_EN
module flit_packetizer (
    input  logic        clk,
    input  logic        arst,
    input  logic        pkt_valid_i,
    output logic        pkt_ready_o,
    input  logic [3:0]  pkt_dest_x_i,
    input  logic [3:0]  pkt_dest_y_i,
    input  logic [3:0]  pkt_len_i,
    input  logic [1:0]  pkt_vc_i,
    input  logic [31:0] word_i,
    input  logic        word_valid_i,
    output logic        word_ready_o,
    output logic [33:0] fdata_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [1:0]  vc_id_o,
`ifdef FLIT_PACKETIZER_PKT_CNT_EN
    output logic [15:0] pkt_cnt_o,
`endif
    output logic        err_o
);

    typedef enum logic {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    localparam logic [1:0] TYPE_HEAD = 2'b00;
    localparam logic [1:0] TYPE_BODY = 2'b01;
    localparam logic [1:0] TYPE_TAIL = 2'b11;

    state_t      state_q, state_d;
    logic [33:0] fdata_q, fdata_d;
    logic        valid_q, valid_d;
    logic [1:0]  vc_q, vc_d;
    logic        err_q, err_d;
    logic [3:0]  cnt_q, cnt_d;

    logic out_free;
    logic route_ok;
    logic pkt_hs;
    logic word_hs;

    // The output register may take a new flit when it is empty or being drained.
    assign out_free = !valid_q || ready_i;
    assign route_ok = ({pkt_dest_x_i, pkt_dest_y_i} != 8'd0);
    assign pkt_hs   = pkt_valid_i && pkt_ready_o;
    assign word_hs  = word_valid_i && word_ready_o;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pkt_hs && route_ok) state_d = PAYLOAD;
            PAYLOAD: if (word_hs && (cnt_q == 4'd0)) state_d = IDLE;
        endcase
    end

    always_comb begin
        pkt_ready_o  = 1'b0;
        word_ready_o = 1'b0;
        case (state_q)
            IDLE:    pkt_ready_o  = out_free;
            PAYLOAD: word_ready_o = out_free;
        endcase
    end

    // Flit datapath. valid drops once the held flit is taken unless a new
    // flit replaces it in the same cycle; a rejected request only pulses err.
    always_comb begin
        fdata_d = fdata_q;
        valid_d = valid_q && !ready_i;
        vc_d    = vc_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        if (pkt_hs) begin
            if (route_ok) begin
                fdata_d = {TYPE_HEAD, 2'b00, pkt_dest_x_i, pkt_dest_y_i, pkt_len_i, 18'd0};
                valid_d = 1'b1;
                vc_d    = pkt_vc_i;
                cnt_d   = pkt_len_i;
            end else begin
                err_d = 1'b1;
            end
        end else if (word_hs) begin
            valid_d = 1'b1;
            if (cnt_q != 4'd0) begin
                fdata_d = {TYPE_BODY, word_i};
                cnt_d   = cnt_q - 4'd1;
            end else begin
                fdata_d = {TYPE_TAIL, word_i};
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            fdata_q <= 34'd0;
            valid_q <= 1'b0;
            vc_q    <= 2'd0;
            err_q   <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            fdata_q <= fdata_d;
            valid_q <= valid_d;
            vc_q    <= vc_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fdata_o = fdata_q;
    assign valid_o = valid_q;
    assign vc_id_o = vc_q;
    assign err_o   = err_q;

`ifdef FLIT_PACKETIZER_PKT_CNT_EN
    logic [15:0] pkt_cnt_q, pkt_cnt_d;

    // Counts packets as their tail leaves the output register; wraps naturally.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (valid_q && ready_i && (fdata_q[33:32] == TYPE_TAIL)) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            pkt_cnt_q <= 16'd0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign pkt_cnt_o = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_flit_packetizer.sv
// tb_flit_packetizer
//
// Self-checking bench for flit_packetizer: a table of packet requests with
// hand-computed head flits, hand-written corner sequences (back-to-back,
// stall, reset mid-packet, optional packet counter) and a randomized run.
// A packet-level reference model (queue of expected flits) watches every
// cycle throughout.
module tb_flit_packetizer;

    logic        clk = 1'b0;
    logic        arst;
    logic        pkt_valid_i;
    logic        pkt_ready_o;
    logic [3:0]  pkt_dest_x_i;
    logic [3:0]  pkt_dest_y_i;
    logic [3:0]  pkt_len_i;
    logic [1:0]  pkt_vc_i;
    logic [31:0] word_i;
    logic        word_valid_i;
    logic        word_ready_o;
    logic [33:0] fdata_o;
    logic        valid_o;
    logic        ready_i;
    logic [1:0]  vc_id_o;
    logic        err_o;
`ifdef FLIT_PACKETIZER_PKT_CNT_EN
    logic [15:0] pkt_cnt_o;
`endif

    always #5 clk = ~clk;

    flit_packetizer dut (
        .clk          (clk),
        .arst         (arst),
        .pkt_valid_i  (pkt_valid_i),
        .pkt_ready_o  (pkt_ready_o),
        .pkt_dest_x_i (pkt_dest_x_i),
        .pkt_dest_y_i (pkt_dest_y_i),
        .pkt_len_i    (pkt_len_i),
        .pkt_vc_i     (pkt_vc_i),
        .word_i       (word_i),
        .word_valid_i (word_valid_i),
        .word_ready_o (word_ready_o),
        .fdata_o      (fdata_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .vc_id_o      (vc_id_o),
`ifdef FLIT_PACKETIZER_PKT_CNT_EN
        .pkt_cnt_o    (pkt_cnt_o),
`endif
        .err_o        (err_o)
    );

    typedef struct {
        logic [3:0]  dx;
        logic [3:0]  dy;
        logic [3:0]  len;
        logic [1:0]  vc;
        logic        exp_err;
        logic [33:0] exp_head;
    } vec_t;

    vec_t vecs[7];

    int checks = 0;
    int passes = 0;

    // Reference model: flits loaded but not yet taken downstream, whether a
    // packet is open, how many payload words it still needs, and the VC /
    // err / packet-count values the outputs should show.
    logic [33:0] m_q[$];
    logic        m_busy;
    int          m_left;
    logic [1:0]  m_vc;
    logic        m_err;
    logic [15:0] m_cnt;

    logic [31:0] w;

    task automatic checkOutput(input string name, input logic [33:0] act, input logic [33:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic pv, input logic [3:0] dx, input logic [3:0] dy,
                                 input logic [3:0] len, input logic [1:0] vc, input logic wv,
                                 input logic [31:0] wd, input logic rdy);
        pkt_valid_i  = pv;
        pkt_dest_x_i = dx;
        pkt_dest_y_i = dy;
        pkt_len_i    = len;
        pkt_vc_i     = vc;
        word_valid_i = wv;
        word_i       = wd;
        ready_i      = rdy;
    endtask

    task automatic resetModel();
        m_q.delete();
        m_busy = 1'b0;
        m_left = 0;
        m_vc   = 2'd0;
        m_err  = 1'b0;
        m_cnt  = 16'd0;
    endtask

    // One clock cycle: inputs were set at the preceding negedge. Compare the
    // registered outputs and the ready signals with the model, then advance
    // the model by the handshakes the coming rising edge will perform.
    task automatic stepCycle();
        logic free;
        logic exp_pr;
        logic exp_wr;
        #1;
        checkOutput("valid_o", 34'(valid_o), 34'(m_q.size() != 0));
        if (m_q.size() != 0) checkOutput("fdata_o", fdata_o, m_q[0]);
        checkOutput("vc_id_o", 34'(vc_id_o), 34'(m_vc));
        checkOutput("err_o", 34'(err_o), 34'(m_err));
`ifdef FLIT_PACKETIZER_PKT_CNT_EN
        checkOutput("pkt_cnt_o", 34'(pkt_cnt_o), 34'(m_cnt));
`endif
        free   = (m_q.size() == 0) || ready_i;
        exp_pr = !m_busy && free;
        exp_wr = m_busy && free;
        checkOutput("pkt_ready_o", 34'(pkt_ready_o), 34'(exp_pr));
        checkOutput("word_ready_o", 34'(word_ready_o), 34'(exp_wr));
        if ((m_q.size() != 0) && ready_i) begin
            if (m_q[0][33:32] == 2'b11) m_cnt = m_cnt + 16'd1;
            void'(m_q.pop_front());
        end
        m_err = 1'b0;
        if (exp_pr && pkt_valid_i) begin
            if ({pkt_dest_x_i, pkt_dest_y_i} == 8'd0) begin
                m_err = 1'b1;
            end else begin
                m_q.push_back({2'b00, 2'b00, pkt_dest_x_i, pkt_dest_y_i, pkt_len_i, 18'd0});
                m_vc   = pkt_vc_i;
                m_busy = 1'b1;
                m_left = int'(pkt_len_i) + 1;
            end
        end else if (exp_wr && word_valid_i) begin
            m_left--;
            m_q.push_back({(m_left == 0) ? 2'b11 : 2'b01, word_i});
            if (m_left == 0) m_busy = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 2'd0, 1'b0, 32'd0, 1'b1);
        arst = 1'b1;
        #1;
        resetModel();
        @(negedge clk);
        arst = 1'b0;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 2'd0, 1'b0, 32'd0, 1'b1);
        stepCycle();
    endtask

    initial begin
        // Packet table: hand-computed head flits for the route/len fields.
        vecs[0] = '{dx: 4'd2,  dy: 4'd3,  len: 4'd0,  vc: 2'd1, exp_err: 1'b0, exp_head: 34'h008C00000};
        vecs[1] = '{dx: 4'd0,  dy: 4'd0,  len: 4'd3,  vc: 2'd2, exp_err: 1'b1, exp_head: 34'h0};
        vecs[2] = '{dx: 4'hF,  dy: 4'hF,  len: 4'hF,  vc: 2'd3, exp_err: 1'b0, exp_head: 34'h03FFC0000};
        vecs[3] = '{dx: 4'd1,  dy: 4'd0,  len: 4'd2,  vc: 2'd0, exp_err: 1'b0, exp_head: 34'h004080000};
        vecs[4] = '{dx: 4'd0,  dy: 4'd1,  len: 4'd1,  vc: 2'd2, exp_err: 1'b0, exp_head: 34'h000440000};
        vecs[5] = '{dx: 4'd0,  dy: 4'd0,  len: 4'd0,  vc: 2'd0, exp_err: 1'b1, exp_head: 34'h0};
        vecs[6] = '{dx: 4'hA,  dy: 4'd5,  len: 4'd7,  vc: 2'd1, exp_err: 1'b0, exp_head: 34'h0295C0000};

        // Reset state
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 2'd0, 1'b0, 32'd0, 1'b1);
        arst = 1'b1;
        resetModel();
        @(negedge clk);
        #1;
        checkOutput("rst_valid", 34'(valid_o), 34'd0);
        checkOutput("rst_fdata", fdata_o, 34'd0);
        checkOutput("rst_vc", 34'(vc_id_o), 34'd0);
        checkOutput("rst_err", 34'(err_o), 34'd0);
        checkOutput("rst_pkt_ready", 34'(pkt_ready_o), 34'd1);
        checkOutput("rst_word_ready", 34'(word_ready_o), 34'd0);
        @(negedge clk);
        arst = 1'b0;

        // Table-driven packets with ready_i held high: no bubbles expected.
        for (int t = 0; t < 7; t++) begin
            applyStimulus(1'b1, vecs[t].dx, vecs[t].dy, vecs[t].len, vecs[t].vc, 1'b0, 32'd0, 1'b1);
            stepCycle();
            checkOutput("tbl_err", 34'(err_o), 34'(vecs[t].exp_err));
            if (vecs[t].exp_err) begin
                checkOutput("tbl_err_noflit", 34'(valid_o), 34'd0);
                idleCycle();
                checkOutput("tbl_err_once", 34'(err_o), 34'd0);
                checkOutput("tbl_err_noflit2", 34'(valid_o), 34'd0);
            end else begin
                checkOutput("tbl_head", fdata_o, vecs[t].exp_head);
                checkOutput("tbl_head_vc", 34'(vc_id_o), 34'(vecs[t].vc));
                for (int i = 0; i <= int'(vecs[t].len); i++) begin
                    w = {8'hA5, 8'(t), 16'(i)};
                    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 2'd0, 1'b1, w, 1'b1);
                    stepCycle();
                    checkOutput("tbl_flit", fdata_o, {(i == int'(vecs[t].len)) ? 2'b11 : 2'b01, w});
                    checkOutput("tbl_flit_valid", 34'(valid_o), 34'd1);
                    checkOutput("tbl_flit_vc", 34'(vc_id_o), 34'(vecs[t].vc));
                end
                idleCycle();
                checkOutput("tbl_idle_valid", 34'(valid_o), 34'd0);
                checkOutput("tbl_idle_vc", 34'(vc_id_o), 34'(vecs[t].vc));
            end
        end

        // Back-to-back tail then head; a request during PAYLOAD and a word
        // during IDLE must both be ignored.
        applyStimulus(1'b1, 4'd1, 4'd1, 4'd0, 2'd2, 1'b0, 32'd0, 1'b1);
        stepCycle();
        checkOutput("b2b_headA", fdata_o, 34'h004400000);
        applyStimulus(1'b1, 4'd1, 4'd2, 4'd0, 2'd3, 1'b1, 32'h11112222, 1'b1);
        stepCycle();
        checkOutput("b2b_tailA", fdata_o, 34'h311112222);
        checkOutput("b2b_tailA_vc", 34'(vc_id_o), 34'd2);
        applyStimulus(1'b1, 4'd1, 4'd2, 4'd0, 2'd3, 1'b1, 32'h55556666, 1'b1);
        stepCycle();
        checkOutput("b2b_headB", fdata_o, 34'h004800000);
        checkOutput("b2b_headB_vc", 34'(vc_id_o), 34'd3);
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 2'd0, 1'b1, 32'h33334444, 1'b1);
        stepCycle();
        checkOutput("b2b_tailB", fdata_o, 34'h333334444);
        idleCycle();

        // Downstream stall for 5 cycles while body flit 3 is presented.
        applyStimulus(1'b1, 4'd4, 4'd4, 4'd4, 2'd1, 1'b0, 32'd0, 1'b1);
        stepCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 2'd0, 1'b1, 32'hC0DE0000 + 32'(i), 1'b1);
            stepCycle();
        end
        for (int s = 0; s < 5; s++) begin
            applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 2'd0, 1'b1, 32'hC0DE0003, 1'b0);
            stepCycle();
            checkOutput("stall_hold", fdata_o, {2'b01, 32'hC0DE0002});
            checkOutput("stall_valid", 34'(valid_o), 34'd1);
            checkOutput("stall_word_ready", 34'(word_ready_o), 34'd0);
        end
        for (int i = 3; i < 5; i++) begin
            applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 2'd0, 1'b1, 32'hC0DE0000 + 32'(i), 1'b1);
            stepCycle();
        end
        checkOutput("stall_tail", fdata_o, {2'b11, 32'hC0DE0004});
        idleCycle();

        // Asynchronous reset after body 2; a fresh packet starts with a head.
        applyStimulus(1'b1, 4'd3, 4'd1, 4'd5, 2'd2, 1'b0, 32'd0, 1'b1);
        stepCycle();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 2'd0, 1'b1, 32'hBEEF0000 + 32'(i), 1'b1);
            stepCycle();
        end
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 2'd0, 1'b0, 32'd0, 1'b0);
        #2;
        arst = 1'b1;
        #1;
        checkOutput("arst_valid", 34'(valid_o), 34'd0);
        checkOutput("arst_fdata", fdata_o, 34'd0);
        checkOutput("arst_vc", 34'(vc_id_o), 34'd0);
        checkOutput("arst_word_ready", 34'(word_ready_o), 34'd0);
        checkOutput("arst_pkt_ready", 34'(pkt_ready_o), 34'd1);
        resetModel();
        @(negedge clk);
        @(negedge clk);
        arst = 1'b0;
        applyStimulus(1'b1, 4'd1, 4'd1, 4'd0, 2'd1, 1'b1, 32'h0BAD0BAD, 1'b1);
        stepCycle();
        checkOutput("post_rst_head_type", 34'(fdata_o[33:32]), 34'd0);
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 2'd0, 1'b1, 32'h600D600D, 1'b1);
        stepCycle();
        idleCycle();

`ifdef FLIT_PACKETIZER_PKT_CNT_EN
        // Packet counter: three packets, then wrap from 0xFFFF.
        doReset();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 4'd2, 4'd2, 4'd0, 2'd0, 1'b0, 32'd0, 1'b1);
            stepCycle();
            applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 2'd0, 1'b1, 32'(k), 1'b1);
            stepCycle();
        end
        idleCycle();
        checkOutput("cnt_three", 34'(pkt_cnt_o), 34'd3);
        dut.pkt_cnt_q = 16'hFFFF;
        m_cnt = 16'hFFFF;
        applyStimulus(1'b1, 4'd2, 4'd2, 4'd0, 2'd0, 1'b0, 32'd0, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 2'd0, 1'b1, 32'h12345678, 1'b1);
        stepCycle();
        idleCycle();
        checkOutput("cnt_wrap", 34'(pkt_cnt_o), 34'd0);
`endif

        // Randomized traffic with backpressure and ignored-input noise.
        doReset();
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] dx;
            logic [3:0] dy;
            dx = 4'($urandom_range(15));
            dy = 4'($urandom_range(15));
            if ($urandom_range(9) == 0) begin
                dx = 4'd0;
                dy = 4'd0;
            end
            applyStimulus(($urandom_range(9) < 6), dx, dy, 4'($urandom_range(15)),
                          2'($urandom_range(3)), ($urandom_range(9) < 7), $urandom,
                          ($urandom_range(9) < 7));
            stepCycle();
        end
        for (int c = 0; c < 4; c++) idleCycle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
